// File: rtl/start_stop_ctrl_if.sv
// Button-to-control handshake bundle for start_stop_ctrl.
// The master side drives the raw buttons. The slave side (the controller) drives the pulses and the running level.
interface start_stop_ctrl_if;
   logic btn_start;
   logic btn_stop;
   logic start;
   logic stop;
   logic clr;
   logic running;

   modport master (output btn_start, btn_stop, input start, stop, clr, running);
   modport slave  (input btn_start, btn_stop, output start, stop, clr, running);
endinterface

// File: rtl/start_stop_ctrl.sv
// Debounced start/stop button front-end driving the downstream counter's start/stop/clr.
// Optional macro START_STOP_AUTO_STOP_EN adds a RUN timeout that forces a stop after RUN_LIMIT cycles.
module start_stop_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DB_WIDTH        = 4,
   parameter int RUN_LIMIT       = 16
) (
   input  logic               clk,
   input  logic               reset,
   start_stop_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   localparam logic [DB_WIDTH-1:0] DB_MAX = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

   // Index 0 is the start button, index 1 is the stop button.
   logic [1:0]               sync1_q, sync2_q, stable_q, prev_q;
   logic [1:0][DB_WIDTH-1:0] cnt_q;
   logic [1:0]               evt;
   logic                     start_evt, stop_evt;

   state_t state_q, state_d;
   logic   start_q, start_d;
   logic   stop_q, stop_d;
   logic   clr_q, clr_d;
   logic   run_q, run_d;
   logic   tmo;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
      end else begin
         sync1_q <= {bus.btn_stop, bus.btn_start};
         sync2_q <= sync1_q;
         prev_q  <= stable_q;
         for (int i = 0; i < 2; i++) begin
            // Any sample agreeing with the accepted level restarts the count.
            if (sync2_q[i] == stable_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == DB_MAX) begin
               stable_q[i] <= sync2_q[i];
               cnt_q[i]    <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign evt       = stable_q & ~prev_q;
   assign start_evt = evt[0];
   assign stop_evt  = evt[1];

`ifdef START_STOP_AUTO_STOP_EN
   localparam int TW = (RUN_LIMIT > 1) ? $clog2(RUN_LIMIT) : 1;
   logic [TW-1:0] tmr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         tmr_q <= '0;
      end else if (state_d == RUN && state_q != RUN) begin
         tmr_q <= '0;
      end else if (state_q == RUN) begin
         tmr_q <= tmr_q + 1'b1;
      end
   end

   assign tmo = (state_q == RUN) && (tmr_q == TW'(RUN_LIMIT - 1));
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      stop_d  = 1'b0;
      clr_d   = 1'b0;
      // Stop takes priority over start whenever both strobes coincide.
      unique case (state_q)
         IDLE: if (start_evt && !stop_evt) begin
            state_d = RUN;
            start_d = 1'b1;
         end
         RUN: if (stop_evt || tmo) begin
            state_d = HALT;
            stop_d  = 1'b1;
         end
         HALT: if (stop_evt) begin
            state_d = IDLE;
            clr_d   = 1'b1;
         end else if (start_evt) begin
            state_d = RUN;
            start_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      run_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         clr_q   <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         clr_q   <= clr_d;
         run_q   <= run_d;
      end
   end

   assign bus.start   = start_q;
   assign bus.stop    = stop_q;
   assign bus.clr     = clr_q;
   assign bus.running = run_q;

endmodule

// File: tb/tb_start_stop_ctrl.sv
// Directed + randomized bench for start_stop_ctrl, checked every cycle against a behavioural model.
module tb_start_stop_ctrl;

   localparam int DB    = 4;
   localparam int LIMIT = 16;
   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   int   n_start = 0;

   start_stop_ctrl_if bus();

   start_stop_ctrl #(.DEBOUNCE_CYCLES(DB), .DB_WIDTH(4), .RUN_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Model: a button level is accepted once DB consecutive synchronized samples disagree with it.
   bit          m_s1[2], m_s2[2], m_stb[2], m_evt[2];
   bit [DB-1:0] m_win[2];
   int          m_fill[2];
   int          m_state, m_tmr;
   bit          e_start, e_stop, e_clr, e_run;

   task automatic model_step(input bit rs, input bit bs, input bit bp);
      bit se, pe, auto_stop, all_diff;
      if (rs) begin
         for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_stb[i] = 0; m_evt[i] = 0; m_win[i] = '0; m_fill[i] = 0;
         end
         m_state = M_IDLE; m_tmr = 0;
         e_start = 0; e_stop = 0; e_clr = 0; e_run = 0;
         return;
      end
      se = m_evt[0]; pe = m_evt[1];
      e_start = 0; e_stop = 0; e_clr = 0;
`ifdef START_STOP_AUTO_STOP_EN
      auto_stop = (m_state == M_RUN) && (m_tmr == LIMIT - 1);
`else
      auto_stop = 0;
`endif
      case (m_state)
         M_IDLE: if (se && !pe) begin m_state = M_RUN; m_tmr = 0; e_start = 1; end
         M_RUN:  if (pe || auto_stop) begin m_state = M_HALT; e_stop = 1; end
                 else m_tmr++;
         default: if (pe) begin m_state = M_IDLE; e_clr = 1; end
                  else if (se) begin m_state = M_RUN; m_tmr = 0; e_start = 1; end
      endcase
      e_run = (m_state == M_RUN);
      for (int i = 0; i < 2; i++) begin
         m_win[i]  = {m_win[i][DB-2:0], m_s2[i]};
         m_fill[i] = (m_fill[i] < DB) ? m_fill[i] + 1 : DB;
         all_diff  = (m_fill[i] == DB) && (m_win[i] == {DB{~m_stb[i]}});
         m_evt[i]  = all_diff && !m_stb[i];
         if (all_diff) m_stb[i] = ~m_stb[i];
         m_s2[i] = m_s1[i];
      end
      m_s1[0] = bs; m_s1[1] = bp;
   endtask

   task automatic check();
      vectors++;
      assert (bus.start === e_start) else begin
         miscompares++; $error("FAIL start obs=%b exp=%b t=%0t", bus.start, e_start, $time);
      end
      assert (bus.stop === e_stop) else begin
         miscompares++; $error("FAIL stop obs=%b exp=%b t=%0t", bus.stop, e_stop, $time);
      end
      assert (bus.clr === e_clr) else begin
         miscompares++; $error("FAIL clr obs=%b exp=%b t=%0t", bus.clr, e_clr, $time);
      end
      assert (bus.running === e_run) else begin
         miscompares++; $error("FAIL running obs=%b exp=%b t=%0t", bus.running, e_run, $time);
      end
   endtask

   task automatic tick(input bit rs, input bit bs, input bit bp);
      reset = rs; bus.btn_start = bs; bus.btn_stop = bp;
      @(posedge clk);
      model_step(rs, bs, bp);
      #1;
      if (bus.start === 1'b1) n_start++;
      check();
   endtask

   task automatic hold(input bit rs, input bit bs, input bit bp, input int n);
      for (int k = 0; k < n; k++) tick(rs, bs, bp);
   endtask

   task automatic press(input bit bs, input bit bp);
      hold(0, bs, bp, 8);
      hold(0, 0, 0, 8);
   endtask

   initial begin
      int lat;
      bit rb, sb, pb;
      bit bounce [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

      // Reset with start held, then measure press latency from reset release.
      hold(1, 1, 0, 3);
      n_start = 0;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         tick(0, 1, 0);
         if (bus.start === 1'b1) lat = k;
      end
      vectors++;
      assert (lat == DB + 3) else begin
         miscompares++; $error("FAIL latency obs=%0d exp=%0d", lat, DB + 3);
      end
      hold(0, 1, 0, 20);
      vectors++;
      assert (n_start == 1) else begin
         miscompares++; $error("FAIL held_pulses obs=%0d exp=1", n_start);
      end
      hold(0, 0, 0, 10);

      // Bounce on a fresh start.
      hold(1, 0, 0, 2);
      foreach (bounce[k]) tick(0, bounce[k], 0);
      hold(0, 1, 0, 10);
      hold(0, 0, 0, 10);

      // start, stop, start, stop, stop -> start, stop, start, stop, clr
      hold(1, 0, 0, 2);
      press(1, 0); press(0, 1); press(1, 0); press(0, 1); press(0, 1);

      // Simultaneous presses in RUN, then back to IDLE and again.
      press(1, 0);
      press(1, 1);
      press(0, 1);
      press(1, 1);

      // Randomized bouncing buttons with occasional resets.
      sb = 0; pb = 0;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 5) == 0) sb = ~sb;
         if ($urandom_range(0, 7) == 0) pb = ~pb;
         rb = ($urandom_range(0, 99) == 0);
         tick(rb, sb, pb);
      end

      // Long idle RUN: the timer (if built in) must stop it.
      hold(0, 0, 0, 10);
      hold(1, 0, 0, 2);
      press(1, 0);
      hold(0, 0, 0, 110);
      vectors++;
`ifdef START_STOP_AUTO_STOP_EN
      assert (bus.running === 1'b0) else begin
         miscompares++; $error("FAIL auto_stop obs=%b exp=0", bus.running);
      end
`else
      assert (bus.running === 1'b1) else begin
         miscompares++; $error("FAIL long_run obs=%b exp=1", bus.running);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
